// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared types and constants for the round-robin decoder arbiter.
package rr_decoder_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    // Decoder enable pattern that forces every output high.
    localparam logic G1_OFF  = 1'b0;
    localparam logic G2A_OFF = 1'b1;
    localparam logic G2B_OFF = 1'b1;

endpackage

// File: rtl/decoder3_8.sv
// 3-to-8 active-low decoder with one active-high and two active-low enables.
module decoder3_8
    import rr_decoder_arbiter_pkg::*;
(
    input  logic [SEL_W-1:0]   a,
    input  logic               g1,
    input  logic               g2a,
    input  logic               g2b,
    output logic [NUM_REQ-1:0] y_n
);

    logic enabled;

    assign enabled = g1 & ~g2a & ~g2b;

    // Select k drives output bit 7-k low, so y_n reads MSB-first by index.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_out
            assign y_n[NUM_REQ-1-gi] = ~(enabled && (a == SEL_W'(gi)));
        end
    endgenerate

endmodule

// File: rtl/rr_decoder_arbiter.sv
// Round-robin arbiter sharing one active-low 3-to-8 decoder between 8 requesters,
// with a hold timeout and a one-cycle dead gap between owners.
module rr_decoder_arbiter
    import rr_decoder_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [SEL_W-1:0]   sel,
    output logic               dec_g1,
    output logic               dec_g2a,
    output logic               dec_g2b,
    output logic [NUM_REQ-1:0] grant_n,
    output logic               grant_valid,
    output logic               timeout
);

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   sel_reg, sel_next;
    logic [SEL_W-1:0]   ptr_reg, ptr_next;
    logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
    logic               timeout_reg, timeout_next;
    logic               g1_reg, g2a_reg, g2b_reg;
    logic               g1_next, g2a_next, g2b_next;

    logic [NUM_REQ-1:0] req_k;
    logic [SEL_W-1:0]   winner;
    logic               any_req;

    // Re-index requests so req_k[k] belongs to requester k.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_k[gi] = req[NUM_REQ-1-gi];
        end
    endgenerate

    assign any_req = |req;

    // Scan offsets from farthest to nearest so the closest requester to ptr wins.
    always_comb begin : p_winner
        logic [SEL_W-1:0] idx;
        winner = ptr_reg;
        idx    = ptr_reg;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr_reg + SEL_W'(i);
            if (req_k[idx]) begin
                winner = idx;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        ptr_next      = ptr_reg;
        hold_cnt_next = hold_cnt_reg;
        timeout_next  = 1'b0;
        unique case (state_reg)
            IDLE, GAP: begin
                if (en && any_req) begin
                    state_next    = GRANT;
                    sel_next      = winner;
                    hold_cnt_next = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            GRANT: begin
                if (!en || !req_k[sel_reg]) begin
                    state_next = GAP;
                    ptr_next   = sel_reg + SEL_W'(1);
                end else if (hold_cnt_reg == CNT_W'(MAX_HOLD - 1)) begin
                    state_next   = GAP;
                    ptr_next     = sel_reg + SEL_W'(1);
                    timeout_next = 1'b1;
                end else begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Enables are registered alongside the state so they switch as one group.
    always_comb begin
        g1_next  = G1_OFF;
        g2a_next = G2A_OFF;
        g2b_next = G2B_OFF;
        if (state_next == GRANT) begin
            g1_next  = 1'b1;
            g2a_next = 1'b0;
            g2b_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            sel_reg      <= '0;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
            g1_reg       <= G1_OFF;
            g2a_reg      <= G2A_OFF;
            g2b_reg      <= G2B_OFF;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            ptr_reg      <= ptr_next;
            hold_cnt_reg <= hold_cnt_next;
            timeout_reg  <= timeout_next;
            g1_reg       <= g1_next;
            g2a_reg      <= g2a_next;
            g2b_reg      <= g2b_next;
        end
    end

    assign sel         = sel_reg;
    assign dec_g1      = g1_reg;
    assign dec_g2a     = g2a_reg;
    assign dec_g2b     = g2b_reg;
    assign grant_valid = (state_reg == GRANT);
    assign timeout     = timeout_reg;

    decoder3_8 u_decoder (
        .a   (sel_reg),
        .g1  (g1_reg),
        .g2a (g2a_reg),
        .g2b (g2b_reg),
        .y_n (grant_n)
    );

endmodule

// File: doc/rr_decoder_arbiter.md
Name: rr_decoder_arbiter

Overview:
- Round-robin arbiter that shares one 3-to-8 active-low decoder between 8 requesters.
- Registers a 3-bit select and the decoder enables (g1, g2a, g2b).
- Exposes the resulting active-low one-hot grant bus by instantiating the decoder.
- Enforces a hold timeout and a one-cycle dead gap between owners, so grant lines never overlap.

Parameters:
- MAX_HOLD, 16: maximum consecutive GRANT cycles per owner before forced revoke; legal range 2..255.
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; low blocks new grants and revokes the current one.
- req  input  8  request vector; requester k (k = 0..7) drives req[7-k], matching decoder select k.
- sel  output  3  registered index of the current owner.
- dec_g1  output  1  decoder enable, active high.
- dec_g2a  output  1  decoder enable, active low.
- dec_g2b  output  1  decoder enable, active low.
- grant_n  output  8  decoder output; bit (7-sel) is low while granted, otherwise 8'hFF.
- grant_valid  output  1  high in the GRANT state.
- timeout  output  1  one-cycle pulse on a forced revoke.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, ptr=0, sel=0, hold_cnt=0.
  - grant_valid=0, timeout=0.
  - dec_g1=0, dec_g2a=1, dec_g2b=1, hence grant_n=8'hFF.
  - Reset overrides everything, including mid-grant: the grant drops on the edge where rst is sampled.
- Enables are driven as a group:
  - GRANT: dec_g1=1, dec_g2a=0, dec_g2b=0.
  - All other states: dec_g1=0, dec_g2a=1, dec_g2b=1.
- Winner selection:
  - Winner = first k in the order ptr, ptr+1, ..., ptr+7 (mod 8) with req[7-k]=1.
  - Pure combinational priority rotate; no extra latency.
- IDLE:
  - If en=1 and any request is high: next state GRANT, sel=winner, hold_cnt=0.
  - Otherwise stay in IDLE.
  - Latency: req sampled at edge N, grant_n low after edge N.
- GRANT, priority order:
  - en=0 → GAP, no timeout pulse.
  - req[7-sel]=0 → GAP.
  - hold_cnt == MAX_HOLD-1 → GAP with timeout=1 for exactly one cycle.
  - Otherwise stay in GRANT, hold_cnt++.
  - On every exit from GRANT, ptr = sel+1 (wraps 7→0).
- GAP:
  - Lasts exactly one cycle with enables inactive (dead cycle between owners).
  - In GAP, arbitration uses the updated ptr.
  - If en=1 and any request is high → GRANT with the new winner; else → IDLE.
- Minimum owner-to-owner spacing is one dead cycle; consecutive grants never share a cycle.
- A lone persistent requester is re-granted after the GAP, so it gets MAX_HOLD cycles on, then 1 cycle off.
- sel holds its last value outside GRANT; downstream logic must qualify it with grant_valid.
- A request that toggles during GRANT for a non-owner has no effect until the next arbitration.
- en falling while in IDLE or GAP has no effect beyond blocking the next grant.
- Arithmetic:
  - ptr and sel are 3-bit and wrap modulo 8.
  - hold_cnt saturates logically because the exit at MAX_HOLD-1 bounds it.

Decomposition:
- Shared package holds:
  - state enum: IDLE=2'd0, GRANT=2'd1, GAP=2'd2;
  - NUM_REQ=8, SEL_W=3;
  - constants for the inactive enable pattern (g1=0, g2a=1, g2b=1).
- One sub-module: instantiate the existing decoder3_8 driven by sel, dec_g1, dec_g2a, dec_g2b to produce grant_n.
- No other hierarchy; the rotate-priority encoder stays inline.

Test Plan:
1. Reset mid-grant: req=8'h80 (k=0), grant up; assert rst for 1 cycle → next cycle grant_n=8'hFF, sel=0, grant_valid=0, ptr=0.
2. Single request: req=8'h10 (k=3) from IDLE → after 1 edge sel=3, grant_n=8'hEF, enables 1/0/0; drop req → next cycle GAP with grant_n=8'hFF, then IDLE.
3. Round-robin fairness: req=8'hFF held, each owner releases after 2 cycles → owners 0,1,2,...,7,0 with one FF cycle between each and never two low bits.
4. Timeout: MAX_HOLD=4, req=8'h01 (k=7) held → grant for exactly 4 cycles, timeout=1 in the first GAP cycle, then re-grant to k=7; ptr wraps to 0.
5. Wrap priority: ptr=6 and req=8'h41 (k=1 and k=7) → k=7 wins; after release, ptr=0 and k=1 wins.
6. Enable drop: grant to k=2 with en falling → next cycle GAP, timeout=0, then IDLE while en=0 despite req=8'hFF; raising en → grant to k=3.
